// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter and access sequencer for the single-ported big-endian data memory.
// Port A (pipeline MEM stage) has priority; port B (debug/DMA) gets a starvation-guard slot.
module dmem_port_arbiter #(
  parameter int MEM_BYTES = 1024,
  parameter int MAX_WAIT  = 4,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [31:0]       a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_stall,
  output logic              a_rvalid,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [31:0]       b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       forced_cnt
);

  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);
  localparam logic [3:0]  WAIT_LIM  = 4'(MAX_WAIT);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr > LAST_WORD);
  endfunction

  logic [3:0] b_wait;
  logic       force_b;

  logic              gnt_p0;
  logic              port_p0;
  logic              we_p0;
  logic [31:0]       addr_p0;
  logic [DATA_W-1:0] wdata_p0;

  logic              vld_p1;
  logic              port_p1;
  logic              we_p1;
  logic              err_p1;
  logic [31:0]       addr_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic              issue_p1;

  logic              vld_p2;
  logic              port_p2;
  logic              err_p2;
  logic [DATA_W-1:0] rdata_p2;

  // Stage p0: grant selection (combinational, single grant per cycle)
  assign force_b = b_req && (b_wait == WAIT_LIM);

  always_comb begin
    a_gnt    = 1'b0;
    b_gnt    = 1'b0;
    if (!rst) begin
      a_gnt = a_req && !force_b;
      b_gnt = b_req && (!a_req || force_b);
    end
    a_stall  = !rst && a_req && !a_gnt;
    gnt_p0   = a_gnt || b_gnt;
    port_p0  = b_gnt;
    we_p0    = b_gnt ? b_we    : a_we;
    addr_p0  = b_gnt ? b_addr  : a_addr;
    wdata_p0 = b_gnt ? b_wdata : a_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_wait     <= 4'd0;
      forced_cnt <= 16'd0;
    end else begin
      if (!b_req || b_gnt) begin
        b_wait <= 4'd0;
      end else begin
        b_wait <= sat_inc4(b_wait);
      end
      if (b_gnt && force_b) begin
        forced_cnt <= sat_inc16(forced_cnt);
      end
    end
  end

  // Stage p1: command register and memory issue
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= gnt_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_p0) begin
      port_p1  <= port_p0;
      we_p1    <= we_p0;
      addr_p1  <= addr_p0;
      wdata_p1 <= wdata_p0;
      err_p1   <= addr_bad(addr_p0);
    end
  end

  // Reset in the issue cycle suppresses the memory access of a dropped command.
  assign issue_p1  = vld_p1 && !err_p1 && !rst;
  assign mem_re    = issue_p1 && !we_p1;
  assign mem_we    = issue_p1 && we_p1;
  assign mem_addr  = issue_p1 ? addr_p1  : 32'd0;
  assign mem_wdata = issue_p1 ? wdata_p1 : '0;

  // Stage p2: response register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p1) begin
      port_p2  <= port_p1;
      err_p2   <= err_p1;
      rdata_p2 <= mem_re ? mem_rdata : '0;
    end
  end

  always_comb begin
    a_rvalid = vld_p2 && !port_p2 && !rst;
    b_rvalid = vld_p2 && port_p2 && !rst;
    a_err    = a_rvalid && err_p2;
    b_err    = b_rvalid && err_p2;
    a_rdata  = a_rvalid ? rdata_p2 : '0;
    b_rdata  = b_rvalid ? rdata_p2 : '0;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a byte-array memory model and a response scoreboard.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [31:0] a_addr = 32'd0, a_wdata = 32'd0;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [31:0] b_addr = 32'd0, b_wdata = 32'd0;
  logic        a_gnt, a_stall, a_rvalid, a_err;
  logic [31:0] a_rdata;
  logic        b_gnt, b_rvalid, b_err;
  logic [31:0] b_rdata;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] forced_cnt;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.MEM_BYTES(1024), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_stall(a_stall), .a_rvalid(a_rvalid), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_err(b_err), .b_rdata(b_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .forced_cnt(forced_cnt)
  );

  // Memory model: big-endian, combinational read, write on clock edge.
  logic [7:0] mem [0:1023];
  logic [7:0] ref_mem [0:1023];
  logic [9:0] ra;
  assign ra = mem_addr[9:0];
  assign mem_rdata = {mem[ra], mem[ra + 10'd1], mem[ra + 10'd2], mem[ra + 10'd3]};

  always @(posedge clk) begin
    if (mem_we) begin
      mem[ra]         <= mem_wdata[31:24];
      mem[ra + 10'd1] <= mem_wdata[23:16];
      mem[ra + 10'd2] <= mem_wdata[15:8];
      mem[ra + 10'd3] <= mem_wdata[7:0];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [9:0] i;
    i = a[9:0];
    return {ref_mem[i], ref_mem[i + 10'd1], ref_mem[i + 10'd2], ref_mem[i + 10'd3]};
  endfunction

  typedef struct {
    logic        port;
    logic        we;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cyc;
  } txn_t;

  txn_t sb[$];
  txn_t iss;
  logic iss_vld = 1'b0;

  // Scoreboard: expected issue one cycle after a grant, expected response two cycles after.
  always @(negedge clk) begin : monitor
    logic er, ew, due, ea_v, eb_v;
    logic [31:0] ea_d, eb_d;
    txn_t t;
    er = iss_vld && !iss.err && !iss.we && !rst;
    ew = iss_vld && !iss.err && iss.we && !rst;
    check1("mem_re", mem_re, er);
    check1("mem_we", mem_we, ew);
    check32("mem_addr", mem_addr, (er || ew) ? iss.addr : 32'd0);
    check32("mem_wdata", mem_wdata, (er || ew) ? iss.wdata : 32'd0);
    if (ew) begin
      ref_mem[iss.addr[9:0]]         = iss.wdata[31:24];
      ref_mem[iss.addr[9:0] + 10'd1] = iss.wdata[23:16];
      ref_mem[iss.addr[9:0] + 10'd2] = iss.wdata[15:8];
      ref_mem[iss.addr[9:0] + 10'd3] = iss.wdata[7:0];
    end

    due = (sb.size() != 0) && (sb[0].cyc + 2 == cyc);
    t = '{port: 1'b0, we: 1'b0, err: 1'b0, addr: 32'd0, wdata: 32'd0, rdata: 32'd0, cyc: 0};
    if (due) t = sb.pop_front();
    if (rst) sb.delete();
    ea_v = due && !t.port && !rst;
    eb_v = due && t.port && !rst;
    ea_d = ea_v ? t.rdata : 32'd0;
    eb_d = eb_v ? t.rdata : 32'd0;
    check1("a_rvalid", a_rvalid, ea_v);
    check1("b_rvalid", b_rvalid, eb_v);
    check1("a_err", a_err, ea_v && t.err);
    check1("b_err", b_err, eb_v && t.err);
    check32("a_rdata", a_rdata, ea_d);
    check32("b_rdata", b_rdata, eb_d);

    iss_vld = 1'b0;
    check1("gnt_exclusive", a_gnt && b_gnt, 1'b0);
    if (a_gnt || b_gnt) begin
      t.port  = !a_gnt;
      t.we    = a_gnt ? a_we : b_we;
      t.addr  = a_gnt ? a_addr : b_addr;
      t.wdata = a_gnt ? a_wdata : b_wdata;
      t.err   = (t.addr[1:0] != 2'b00) || (t.addr > 32'd1020);
      t.rdata = (t.err || t.we) ? 32'd0 : ref_word(t.addr);
      t.cyc   = cyc;
      sb.push_back(t);
      iss     = t;
      iss_vld = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    mem[3] = 8'h01; mem[7] = 8'h01;
    ref_mem[3] = 8'h01; ref_mem[7] = 8'h01;

    // Reset state, with requests present to show grants are held off
    @(posedge clk); #1;
    a_req = 1'b1; b_req = 1'b1;
    @(negedge clk);
    check1("rst_a_gnt", a_gnt, 1'b0);
    check1("rst_b_gnt", b_gnt, 1'b0);
    check1("rst_a_stall", a_stall, 1'b0);
    check1("rst_mem_re", mem_re, 1'b0);
    check32("rst_forced_cnt", 32'(forced_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; a_req = 1'b0; b_req = 1'b0;

    // A reads addr 0
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'd0;
    @(negedge clk);
    check1("t1_a_gnt", a_gnt, 1'b1);
    @(posedge clk); #1;
    a_req = 1'b0;
    @(negedge clk);
    check1("t1_mem_re", mem_re, 1'b1);
    check32("t1_mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check1("t1_a_rvalid", a_rvalid, 1'b1);
    check32("t1_a_rdata", a_rdata, 32'h0000_0001);
    check1("t1_a_err", a_err, 1'b0);

    // Write then read-after-write on addr 8
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'd8; a_wdata = 32'h0000_0090;
    @(negedge clk);
    check1("t2_wr_gnt", a_gnt, 1'b1);
    @(posedge clk); #1;
    a_we = 1'b0;
    @(negedge clk);
    check1("t2_rd_gnt", a_gnt, 1'b1);
    check1("t2_mem_we", mem_we, 1'b1);
    @(posedge clk); #1;
    a_req = 1'b0;
    @(negedge clk);
    check1("t2_wr_ack", a_rvalid, 1'b1);
    check32("t2_wr_ack_data", a_rdata, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check1("t2_rd_rvalid", a_rvalid, 1'b1);
    check32("t2_rd_data", a_rdata, 32'h0000_0090);

    // Both ports held: B forced every fifth cycle
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'd4;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check1("starve_a_gnt", a_gnt, (i % 5) != 4);
      check1("starve_b_gnt", b_gnt, (i % 5) == 4);
      check1("starve_a_stall", a_stall, (i % 5) == 4);
      check32("starve_forced_cnt", 32'(forced_cnt), 32'(i / 5));
      @(posedge clk); #1;
    end
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    check32("starve_forced_final", 32'(forced_cnt), 32'd2);

    // B misaligned and out-of-range reads
    @(posedge clk); #1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'd6;
    @(negedge clk);
    check1("t4_gnt_mis", b_gnt, 1'b1);
    @(posedge clk); #1;
    b_addr = 32'd1024;
    @(negedge clk);
    check1("t4_gnt_oor", b_gnt, 1'b1);
    check1("t4_mem_re_mis", mem_re, 1'b0);
    @(posedge clk); #1;
    b_req = 1'b0;
    @(negedge clk);
    check1("t4_b_err_mis", b_err, 1'b1);
    check1("t4_mem_re_oor", mem_re, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check1("t4_b_err_oor", b_err, 1'b1);
    check32("t4_b_rdata_oor", b_rdata, 32'd0);

    // Write to addr 12 dropped by reset in its issue cycle
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 32'd12; a_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check1("t5_gnt", a_gnt, 1'b1);
    @(posedge clk); #1;
    a_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    check1("t5_no_mem_we", mem_we, 1'b0);
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'd12;
    @(negedge clk);
    check1("t5_no_rvalid", a_rvalid, 1'b0);
    check1("t5_rst_gnt", a_gnt, 1'b0);
    check1("t5_rst_stall", a_stall, 1'b0);
    check32("t5_rst_forced", 32'(forced_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check1("t5_rd_gnt", a_gnt, 1'b1);
    @(posedge clk); #1;
    a_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check1("t5_rd_rvalid", a_rvalid, 1'b1);
    check32("t5_rd_data", a_rdata, 32'd0);

    // Interleaved A, B, A
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'd8;
    @(negedge clk);
    check1("t6_gnt_a0", a_gnt, 1'b1);
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 32'd4;
    @(negedge clk);
    check1("t6_gnt_b", b_gnt, 1'b1);
    @(posedge clk); #1;
    b_req = 1'b0; a_req = 1'b1; a_we = 1'b1; a_addr = 32'd16; a_wdata = 32'h0000_0055;
    @(negedge clk);
    check1("t6_gnt_a1", a_gnt, 1'b1);
    check1("t6_rsp0_a", a_rvalid, 1'b1);
    check32("t6_rsp0_data", a_rdata, 32'h0000_0090);
    check32("t6_rsp0_b_quiet", b_rdata, 32'd0);
    @(posedge clk); #1;
    a_req = 1'b0;
    @(negedge clk);
    check1("t6_rsp1_b", b_rvalid, 1'b1);
    check32("t6_rsp1_data", b_rdata, 32'h0000_0001);
    check32("t6_rsp1_a_quiet", a_rdata, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check1("t6_rsp2_a", a_rvalid, 1'b1);
    check1("t6_rsp2_b_quiet", b_rvalid, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
